// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-memory boot loader: word geometry,
// loader state encoding and the byte-lane placement helper.
package pipeline_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2,
        ERR   = 2'd3
    } ld_state_e;

    // Place a byte into its big-endian lane: index 0 lands in [31:24].
    function automatic logic [WORD_W-1:0] place_byte(input logic [7:0] b,
                                                     input logic [IDX_W-1:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = {b, 24'h00_0000};
            2'd1:    w = {8'h00, b, 16'h0000};
            2'd2:    w = {16'h0000, b, 8'h00};
            2'd3:    w = {24'h00_0000, b};
            default: w = {WORD_W{1'b0}};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects host bytes into a big-endian word. The accumulator is cleared after
// every completed word, so a word closed early by "last" is zero-filled in its
// low lanes without any extra masking.
module byte_packer
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              accept_i,
    input  logic [7:0]        data_i,
    input  logic              last_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o,
    output logic              partial_o
);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              idx_full_s;

    assign idx_full_s   = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word_o       = acc_q | place_byte(data_i, idx_q);
    assign word_ready_o = accept_i & (idx_full_s | last_i);
    assign partial_o    = last_i & ~idx_full_s;

    // Next accumulator and byte index: clear on restart or word completion, shift on accept.
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (clr_i || word_ready_o) begin
            acc_d = {WORD_W{1'b0}};
            idx_d = {IDX_W{1'b0}};
        end else if (accept_i) begin
            acc_d = word_o;
            idx_d = idx_q + IDX_W'(1);
        end else begin
            acc_d = acc_q;
            idx_d = idx_q;
        end
    end

    // Accumulator and byte index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {WORD_W{1'b0}};
            idx_q <= {IDX_W{1'b0}};
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a host byte stream into words,
// writes them at consecutive addresses and holds the CPU in reset until the
// final word has been written.
module imem_loader
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    ld_state_e         state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              last_q, last_d;
    logic              partial_q, partial_d;

    logic              accept_s;
    logic              restart_s;
    logic [WORD_W-1:0] word_s;
    logic              word_ready_s;
    logic              pk_partial_s;

    // in_ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign accept_s  = in_valid & in_ready_q;
    assign restart_s = (state_q == RUN) & reload;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (reset),
        .clr_i        (restart_s),
        .accept_i     (accept_s),
        .data_i       (in_data),
        .last_i       (in_last),
        .word_o       (word_s),
        .word_ready_o (word_ready_s),
        .partial_o    (pk_partial_s)
    );

    // Loader FSM next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;
        wl_d        = wl_q;
        last_d      = last_q;
        partial_d   = partial_q;
        case (state_q)
            LOAD: begin
                if (word_ready_s) begin
                    state_d   = WRITE;
                    we_d      = 1'b1;
                    addr_d    = wl_q[ADDR_W-1:0];
                    wdata_d   = word_s;
                    last_d    = in_last;
                    partial_d = pk_partial_s;
                end else begin
                    state_d = LOAD;
                end
            end
            WRITE: begin
                wl_d = wl_q + (ADDR_W+1)'(1);
                if (last_q) begin
                    // A short final word still releases the CPU, but flagged.
                    state_d     = RUN;
                    cpu_reset_d = 1'b0;
                    done_d      = ~partial_q;
                    error_d     = partial_q;
                end else if (wl_q == (ADDR_W+1)'(DEPTH - 1)) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d     = LOAD;
                    wl_d        = {(ADDR_W+1){1'b0}};
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cpu_reset_d = 1'b1;
                    last_d      = 1'b0;
                    partial_d   = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d     = ERR;
                error_d     = 1'b1;
                done_d      = 1'b0;
                cpu_reset_d = 1'b1;
            end
        endcase
        in_ready_d = (state_d == LOAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {WORD_W{1'b0}};
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wl_q        <= {(ADDR_W+1){1'b0}};
            last_q      <= 1'b0;
            partial_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wl_q        <= wl_d;
            last_q      <= last_d;
            partial_q   <= partial_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule
